siso: RTL and testbench

- Parameterised serial-in/serial-out shift register used as a fixed bit delay line on single-bit serial paths.
- Each rising clock edge shifts `sin` into stage 0 and moves every stage one position toward the output. `sdo` presents the oldest bit.
- Also exposes a parallel tap view and a fill indicator for debug and verification.

---
 rtl/siso_pkg.sv | 11 +
 rtl/siso_stage.sv | 17 +
 rtl/siso.sv | 63 ++++++
 tb/tb_siso.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// Shared constants and helpers for the siso serial delay line.
package siso_pkg;

    localparam int unsigned SISO_DEPTH_DEFAULT = 4;

    // Fill counter must hold values 0..depth inclusive.
    function automatic int unsigned siso_cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/siso_stage.sv
// Single delay-line stage: one flip-flop with synchronous active-low clear.
module siso_stage (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/siso.sv
// Parameterised serial-in/serial-out delay line with parallel tap view and fill flag.
module siso
    import siso_pkg::*;
#(
    parameter int unsigned DEPTH = SISO_DEPTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    output logic             sdo,
    output logic [DEPTH-1:0] taps,
    output logic             full
);

    localparam int unsigned CW = siso_cnt_width(DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [DEPTH-1:0] stage;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             full_r;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            siso_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (sin),
                .q     (stage[0])
            );
        end else begin : g_chain
            siso_stage u_stage (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (stage[i-1]),
                .q     (stage[i])
            );
        end
    end

    // Saturating count of edges since reset; full is registered from the next value.
    always_comb begin
        count_nxt = count;
        if (count != CNT_MAX) begin
            count_nxt = count + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            full_r <= 1'b0;
        end else begin
            count  <= count_nxt;
            full_r <= (count_nxt == CNT_MAX);
        end
    end

    assign taps = stage;
    assign sdo  = stage[DEPTH-1];
    assign full = full_r;

endmodule

// File: tb/tb_siso.sv
// Self-checking bench for siso at DEPTH=4 and DEPTH=1 against a queue-based history model.
module tb_siso;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sin = 1'b0;
    logic       sdo4, full4;
    logic [3:0] taps4;
    logic       sdo1, full1;
    logic [0:0] taps1;

    int checks = 0;
    int errors = 0;

    // Bits sampled since the last reset, newest first.
    bit hist[$];

    always #5 clk = ~clk;

    siso #(.DEPTH(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .sdo   (sdo4),
        .taps  (taps4),
        .full  (full4)
    );

    siso #(.DEPTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .sin   (sin),
        .sdo   (sdo1),
        .taps  (taps1),
        .full  (full1)
    );

    function automatic logic [3:0] exp_taps4();
        logic [3:0] t = '0;
        for (int i = 0; i < 4; i++) begin
            if (i < hist.size()) t[i] = hist[i];
        end
        return t;
    endfunction

    function automatic logic [5:0] exp_vec4();
        logic [3:0] t = exp_taps4();
        return {t[3], (hist.size() >= 4) ? 1'b1 : 1'b0, t};
    endfunction

    function automatic logic [2:0] exp_vec1();
        logic b = (hist.size() >= 1) ? hist[0] : 1'b0;
        return {b, (hist.size() >= 1) ? 1'b1 : 1'b0, b};
    endfunction

    // Drive one cycle of inputs, advance the model on the edge, settle before checks.
    task automatic step(input logic s, input logic r);
        @(negedge clk);
        sin   = s;
        rst_n = r;
        @(posedge clk);
        if (!r) begin
            hist.delete();
        end else begin
            hist.push_front(s);
            if (hist.size() > 64) void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic test_reset();
        for (int e = 0; e < 2; e++) begin
            step(1'b1, 1'b0);
            checks++;
            if ({sdo4, full4, taps4} !== 6'b000000) begin
                errors++;
                $display("FAIL reset4 edge %0d: got sdo/full/taps %b required 000000", e, {sdo4, full4, taps4});
            end
            checks++;
            if ({sdo1, full1, taps1} !== 3'b000) begin
                errors++;
                $display("FAIL reset1 edge %0d: got sdo/full/taps %b required 000", e, {sdo1, full1, taps1});
            end
        end
    endtask

    task automatic test_pattern();
        logic [4:0]  pat      = 5'b10101;
        logic [19:0] exp_taps = {4'b0101, 4'b1010, 4'b0101, 4'b0010, 4'b0001};
        logic [4:0]  exp_sdo  = 5'b01000;
        logic [4:0]  exp_full = 5'b11000;
        for (int e = 0; e < 5; e++) begin
            step(pat[e], 1'b1);
            checks++;
            if ({sdo4, full4, taps4} !== {exp_sdo[e], exp_full[e], exp_taps[e*4 +: 4]}) begin
                errors++;
                $display("FAIL pattern edge %0d: got sdo/full/taps %b required %b", e + 1,
                         {sdo4, full4, taps4}, {exp_sdo[e], exp_full[e], exp_taps[e*4 +: 4]});
            end
        end
    endtask

    task automatic test_latency();
        step(1'b0, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            step((e == 2) ? 1'b1 : 1'b0, 1'b1);
            checks++;
            if (sdo4 !== ((e == 5) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL latency edge %0d: got sdo %b required %b", e, sdo4, (e == 5) ? 1'b1 : 1'b0);
            end
            checks++;
            if (sdo1 !== ((e == 2) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL latency1 edge %0d: got sdo %b required %b", e, sdo1, (e == 2) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_midreset();
        for (int e = 0; e < 4; e++) step(1'b1, 1'b1);
        checks++;
        if ({full4, taps4} !== 5'b11111) begin
            errors++;
            $display("FAIL midreset_load: got full/taps %b required 11111", {full4, taps4});
        end
        step(1'b1, 1'b0);
        checks++;
        if ({sdo4, full4, taps4} !== 6'b000000) begin
            errors++;
            $display("FAIL midreset_clear: got sdo/full/taps %b required 000000", {sdo4, full4, taps4});
        end
        for (int e = 1; e <= 6; e++) begin
            step(1'b1, 1'b1);
            checks++;
            if (sdo4 !== ((e >= 4) ? 1'b1 : 1'b0) || full4 !== ((e >= 4) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL midreset_refill edge %0d: got sdo %b full %b required %b", e, sdo4, full4,
                         (e >= 4) ? 1'b1 : 1'b0);
            end
        end
    endtask

    task automatic test_saturation();
        for (int e = 0; e < 20; e++) begin
            step(1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (full4 !== 1'b1 || u_dut.count !== 3'd4 || taps4 !== exp_taps4()) begin
                errors++;
                $display("FAIL saturation edge %0d: got full %b count %0d taps %b required 1 4 %b",
                         e, full4, u_dut.count, taps4, exp_taps4());
            end
        end
    endtask

    task automatic test_random();
        for (int e = 0; e < 300; e++) begin
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1);
            checks++;
            if ({sdo4, full4, taps4} !== exp_vec4()) begin
                errors++;
                $display("FAIL random4 edge %0d: got sdo/full/taps %b required %b", e, {sdo4, full4, taps4}, exp_vec4());
            end
            checks++;
            if ({sdo1, full1, taps1} !== exp_vec1()) begin
                errors++;
                $display("FAIL random1 edge %0d: got sdo/full/taps %b required %b", e, {sdo1, full1, taps1}, exp_vec1());
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pattern();
        test_latency();
        test_midreset();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
